// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI mode 0 register-file peripheral with synchronized inputs
module spi_reg_peripheral #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int CMD_BITS = 1 + ADDR_W;
  localparam int FRAME    = CMD_BITS + DATA_W;
  localparam int CNT_W    = $clog2(FRAME + 2);
  localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME + 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, OVER} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0]     sclk_sync, copi_sync, ncs_sync;
  logic                       sclk_d, ncs_d;
  logic                       sclk_s, copi_s, ncs_s;
  logic                       sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  logic [CNT_W-1:0]           cnt;
  logic [FRAME-1:0]           in_sr, sr_next;
  logic [DATA_W-1:0]          out_sr, rd_val, fr_data;
  logic [ADDR_W-1:0]          cap_addr, fr_addr;
  logic                       rd_frame, cipo_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                       fr_rw, fr_full, fr_in_range, do_write, do_err;

  // Input synchronizers plus one-cycle-delayed copies for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], COPI};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];

  // SCLK edges only count while selected, so an nCS rise always wins over them
  assign sclk_rise = sclk_s & ~sclk_d & ~ncs_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~ncs_s;
  assign ncs_fall  = ~ncs_s & ncs_d;
  assign ncs_rise  = ncs_s & ~ncs_d;

  assign sr_next  = {in_sr[FRAME-2:0], copi_s};
  assign cap_addr = sr_next[ADDR_W-1:0];

  assign fr_rw       = in_sr[FRAME-1];
  assign fr_addr     = in_sr[DATA_W +: ADDR_W];
  assign fr_data     = in_sr[DATA_W-1:0];
  assign fr_full     = (state == DATA) && (cnt == CNT_FRAME);
  assign fr_in_range = 32'(fr_addr) < 32'(NUM_REGS);
  assign do_write    = ncs_rise & fr_full & fr_rw & fr_in_range;
  assign do_err      = ncs_rise & (state != IDLE) & ~(fr_full & fr_in_range);

  // Read mux; unimplemented addresses read as zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cap_addr == ADDR_W'(i)) rd_val = regs_q[i*DATA_W +: DATA_W];
    end
  end

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; nCS rise returns to IDLE from anywhere
  always_comb begin
    state_nx = state;
    if (ncs_rise) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (ncs_fall) state_nx = CMD;
        CMD:     if (sclk_rise && cnt == CNT_CMD_LAST) state_nx = DATA;
        DATA:    if (sclk_rise && cnt >= CNT_FRAME) state_nx = OVER;
        default: state_nx = state;
      endcase
    end
  end

  // Bit counter, input shifter, read capture and CIPO shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      in_sr    <= '0;
      out_sr   <= '0;
      rd_frame <= 1'b0;
      cipo_q   <= 1'b0;
    end else begin
      if (ncs_fall || state == IDLE) cnt <= '0;
      else if (sclk_rise && cnt != CNT_SAT) cnt <= cnt + 1'b1;

      if (ncs_fall) in_sr <= '0;
      else if (sclk_rise && (state == CMD || state == DATA)) in_sr <= sr_next;

      if (ncs_fall) begin
        rd_frame <= 1'b0;
        cipo_q   <= 1'b0;
        out_sr   <= '0;
      end else if (sclk_rise && state == CMD && cnt == CNT_CMD_LAST) begin
        rd_frame <= ~sr_next[ADDR_W];
        out_sr   <= sr_next[ADDR_W] ? '0 : rd_val;
      end else if (sclk_fall && state == DATA) begin
        cipo_q <= out_sr[DATA_W-1];
        out_sr <= out_sr << 1;
      end
    end
  end

  // Register file commit and one-cycle status pulses at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= do_write;
      frame_err <= do_err;
      if (do_write) begin
        wr_addr <= fr_addr;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (fr_addr == ADDR_W'(i)) regs_q[i*DATA_W +: DATA_W] <= fr_data;
        end
      end
    end
  end

  assign CIPO      = (state == DATA && rd_frame) ? cipo_q : 1'b0;
  assign cipo_oe   = ~ncs_s;
  assign regs_flat = regs_q;

endmodule
